// File: rtl/sfp_mon_pkg.sv
// Shared types and constants for the SFP/SerDes link monitor.
// Holds the link states, the LED patterns and the drop counter width.
package sfp_mon_pkg;

   localparam int DROP_CNT_W = 8;

   typedef enum logic [2:0] {
      DOWN = 3'd0,
      PLL  = 3'd1,
      SIG  = 3'd2,
      QUAL = 3'd3,
      UP   = 3'd4
   } link_state_t;

   typedef enum logic [1:0] {
      LED_OFF  = 2'd0,
      LED_FAST = 2'd1,
      LED_SLOW = 2'd2,
      LED_ON   = 2'd3
   } led_pat_t;

   function automatic led_pat_t led_pattern(input link_state_t st);
      led_pat_t pat;
      case (st)
         PLL:       pat = LED_FAST;
         SIG, QUAL: pat = LED_SLOW;
         UP:        pat = LED_ON;
         default:   pat = LED_OFF;
      endcase
      return pat;
   endfunction

   // Active-low drive: a blinking LED is lit while its phase bit is high.
   function automatic logic led_drive_n(input led_pat_t pat, input logic fast, input logic slow);
      logic drv_n;
      case (pat)
         LED_FAST: drv_n = ~fast;
         LED_SLOW: drv_n = ~slow;
         LED_ON:   drv_n = 1'b0;
         default:  drv_n = 1'b1;
      endcase
      return drv_n;
   endfunction

endpackage

// File: rtl/sfp_mon_chan.sv
// One link-monitor channel: input synchroniser, link FSM, qualify/hold
// timers, clear-button debouncer and saturating link-drop counter.
//
//   state | meaning
//   ------+-----------------------------------------------------
//   DOWN  | no PLL lock
//   PLL   | PLL locked, waiting for signal detect without LOS
//   SIG   | signal present, waiting for CDR lock
//   QUAL  | all locks held, qualify counter running
//   UP    | link qualified and up
module sfp_mon_chan
   import sfp_mon_pkg::*;
#(
   parameter int DEBOUNCE_CYC   = 1_000_000,
   parameter int TXDIS_HOLD_CYC = 65_536,
   parameter int UP_QUAL_CYC    = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pll_lock,
   input  logic                  cdr_lock,
   input  logic                  sig_det,
   input  logic                  sfp_los,
   input  logic                  btn_clear,
   input  logic                  blink_fast,
   input  logic                  blink_slow,
   output logic                  sfp_tx_disable,
   output logic                  ber_clear,
   output logic                  blkerr_clear,
   output logic                  link_up,
   output logic [DROP_CNT_W-1:0] drop_cnt,
   output logic                  led_n
);

   localparam int QUAL_W = $clog2(UP_QUAL_CYC + 1);
   localparam int HOLD_W = $clog2(TXDIS_HOLD_CYC + 1);
   localparam int DEB_W  = $clog2(DEBOUNCE_CYC + 1);

   localparam logic [QUAL_W-1:0]     QUAL_LAST = QUAL_W'(UP_QUAL_CYC - 1);
   localparam logic [HOLD_W-1:0]     HOLD_DONE = HOLD_W'(TXDIS_HOLD_CYC);
   localparam logic [DEB_W-1:0]      DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
   localparam logic [DEB_W-1:0]      DEB_DONE  = DEB_W'(DEBOUNCE_CYC);
   localparam logic [DROP_CNT_W-1:0] DROP_MAX  = '1;

   // LOS resets to "present" so TX stays off until a real low LOS is seen.
   localparam logic [4:0] SYNC_RST = 5'b01000;

   logic [4:0] sync_q1, sync_q2;
   logic       pll_lock_s, cdr_lock_s, sig_det_s, sfp_los_s, btn_clear_s;

   link_state_t       state, state_nxt;
   logic [QUAL_W-1:0] qual_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [DEB_W-1:0]  deb_cnt;
   logic              sig_ok, qual_done, drop_evt, clear_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= SYNC_RST;
         sync_q2 <= SYNC_RST;
      end else begin
         sync_q1 <= {btn_clear, sfp_los, sig_det, cdr_lock, pll_lock};
         sync_q2 <= sync_q1;
      end
   end

   assign pll_lock_s  = sync_q2[0];
   assign cdr_lock_s  = sync_q2[1];
   assign sig_det_s   = sync_q2[2];
   assign sfp_los_s   = sync_q2[3];
   assign btn_clear_s = sync_q2[4];

   assign sig_ok    = sig_det_s & ~sfp_los_s;
   assign qual_done = (qual_cnt == QUAL_LAST);
   assign clear_hit = btn_clear_s & (deb_cnt == DEB_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= DOWN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      drop_evt  = 1'b0;
      if (!pll_lock_s) begin
         state_nxt = DOWN;
      end else begin
         case (state)
            DOWN: state_nxt = PLL;
            PLL:  if (sig_ok) state_nxt = SIG;
            SIG: begin
               if (!sig_ok)        state_nxt = PLL;
               else if (cdr_lock_s) state_nxt = QUAL;
            end
            QUAL: begin
               if (!sig_ok)          state_nxt = PLL;
               else if (!cdr_lock_s) state_nxt = SIG;
               else if (qual_done)   state_nxt = UP;
            end
            UP: begin
               if (!sig_ok)          state_nxt = PLL;
               else if (!cdr_lock_s) state_nxt = SIG;
            end
            default: state_nxt = DOWN;
         endcase
      end
      if ((state == UP) && (state_nxt != UP)) drop_evt = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         qual_cnt       <= '0;
         hold_cnt       <= '0;
         sfp_tx_disable <= 1'b1;
         deb_cnt        <= '0;
         ber_clear      <= 1'b0;
         blkerr_clear   <= 1'b0;
         drop_cnt       <= '0;
         link_up        <= 1'b0;
         led_n          <= 1'b1;
      end else begin
         if ((state == QUAL) && (state_nxt == QUAL)) qual_cnt <= qual_cnt + 1'b1;
         else                                       qual_cnt <= '0;

         // Hold counter saturates; TX re-enables only after a full LOS-low run.
         sfp_tx_disable <= sfp_los_s | (hold_cnt != HOLD_DONE);
         if (sfp_los_s)                  hold_cnt <= '0;
         else if (hold_cnt != HOLD_DONE) hold_cnt <= hold_cnt + 1'b1;

         // Saturation at DEB_DONE gives one pulse per press however long it is held.
         if (!btn_clear_s)             deb_cnt <= '0;
         else if (deb_cnt != DEB_DONE) deb_cnt <= deb_cnt + 1'b1;
         ber_clear    <= clear_hit;
         blkerr_clear <= clear_hit;

         if (clear_hit)                          drop_cnt <= '0;
         else if (drop_evt && drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 1'b1;

         link_up <= (state == UP);
         led_n   <= led_drive_n(led_pattern(state), blink_fast, blink_slow);
      end
   end

endmodule

// File: rtl/sfp_link_monitor.sv
// Per-channel SFP/SerDes link supervisor: one monitor channel per link
// plus the LED phase counter shared by every channel.
module sfp_link_monitor
   import sfp_mon_pkg::*;
#(
   parameter int NUM_CH         = 2,
   parameter int DEBOUNCE_CYC   = 1_000_000,
   parameter int BLINK_DIV_LOG2 = 24,
   parameter int TXDIS_HOLD_CYC = 65_536,
   parameter int UP_QUAL_CYC    = 4096
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH-1:0]            pll_lock,
   input  logic [NUM_CH-1:0]            cdr_lock,
   input  logic [NUM_CH-1:0]            sig_det,
   input  logic [NUM_CH-1:0]            sfp_los,
   input  logic [NUM_CH-1:0]            btn_clear,
   output logic [NUM_CH-1:0]            sfp_tx_disable,
   output logic [NUM_CH-1:0]            ber_clear,
   output logic [NUM_CH-1:0]            blkerr_clear,
   output logic [NUM_CH-1:0]            link_up,
   output logic [NUM_CH*DROP_CNT_W-1:0] drop_cnt,
   output logic [NUM_CH-1:0]            leds_n
);

   logic [BLINK_DIV_LOG2-1:0] blink_cnt;
   logic                      blink_fast, blink_slow;

   always_ff @(posedge clk) begin
      if (rst) blink_cnt <= '0;
      else     blink_cnt <= blink_cnt + 1'b1;
   end

   assign blink_fast = blink_cnt[BLINK_DIV_LOG2-3];
   assign blink_slow = blink_cnt[BLINK_DIV_LOG2-1];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      sfp_mon_chan #(
         .DEBOUNCE_CYC  (DEBOUNCE_CYC),
         .TXDIS_HOLD_CYC(TXDIS_HOLD_CYC),
         .UP_QUAL_CYC   (UP_QUAL_CYC)
      ) u_chan (
         .clk           (clk),
         .rst           (rst),
         .pll_lock      (pll_lock[i]),
         .cdr_lock      (cdr_lock[i]),
         .sig_det       (sig_det[i]),
         .sfp_los       (sfp_los[i]),
         .btn_clear     (btn_clear[i]),
         .blink_fast    (blink_fast),
         .blink_slow    (blink_slow),
         .sfp_tx_disable(sfp_tx_disable[i]),
         .ber_clear     (ber_clear[i]),
         .blkerr_clear  (blkerr_clear[i]),
         .link_up       (link_up[i]),
         .drop_cnt      (drop_cnt[DROP_CNT_W*i +: DROP_CNT_W]),
         .led_n         (leds_n[i])
      );
   end

endmodule

// File: tb/tb_sfp_link_monitor.sv
// Bench for sfp_link_monitor: directed scenarios plus random pin activity,
// every cycle compared against a behavioural model of the link rules.
module tb_sfp_link_monitor;

   localparam int NUM_CH = 2;
   localparam int DEB    = 20;
   localparam int BLK    = 5;
   localparam int HOLD   = 40;
   localparam int QUAL   = 16;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NUM_CH-1:0]     pll_lock = '1, cdr_lock = '1, sig_det = '1, sfp_los = '0, btn_clear = '0;
   logic [NUM_CH-1:0]     sfp_tx_disable, ber_clear, blkerr_clear, link_up, leds_n;
   logic [NUM_CH*8-1:0]   drop_cnt;

   always #5 clk = ~clk;

   sfp_link_monitor #(
      .NUM_CH(NUM_CH), .DEBOUNCE_CYC(DEB), .BLINK_DIV_LOG2(BLK),
      .TXDIS_HOLD_CYC(HOLD), .UP_QUAL_CYC(QUAL)
   ) dut (
      .clk(clk), .rst(rst), .pll_lock(pll_lock), .cdr_lock(cdr_lock), .sig_det(sig_det),
      .sfp_los(sfp_los), .btn_clear(btn_clear), .sfp_tx_disable(sfp_tx_disable),
      .ber_clear(ber_clear), .blkerr_clear(blkerr_clear), .link_up(link_up),
      .drop_cnt(drop_cnt), .leds_n(leds_n)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: inputs seen two cycles late; the link climbs one
   // level per cycle while allowed and falls straight to the highest level
   // its conditions still permit.
   bit                  m_valid = 1'b0;
   int                  m_cyc;
   int                  m_st[NUM_CH], m_qual_age[NUM_CH], m_los_run[NUM_CH];
   int                  m_press_run[NUM_CH], m_drops[NUM_CH];
   bit [4:0]            m_d1[NUM_CH], m_d2[NUM_CH];
   logic [NUM_CH-1:0]   m_txdis, m_pulse, m_up, m_led;
   logic [NUM_CH*8-1:0] m_drop_vec;
   bit                  s_pll, s_cdr, s_sig, s_los, s_btn, ph_fast, ph_slow;
   int                  cap, nst;

   always @(posedge clk) begin
      m_valid = 1'b1;
      if (rst) begin
         m_cyc = 0;
         for (int c = 0; c < NUM_CH; c++) begin
            m_d1[c] = 5'b01000; m_d2[c] = 5'b01000;
            m_st[c] = 0; m_qual_age[c] = 0; m_los_run[c] = 0;
            m_press_run[c] = 0; m_drops[c] = 0;
         end
         m_txdis = '1; m_pulse = '0; m_up = '0; m_led = '1; m_drop_vec = '0;
      end else begin
         ph_fast = m_cyc[BLK-3];
         ph_slow = m_cyc[BLK-1];
         for (int c = 0; c < NUM_CH; c++) begin
            {s_btn, s_los, s_sig, s_cdr, s_pll} = m_d2[c];
            m_up[c] = (m_st[c] == 4);
            case (m_st[c])
               0:       m_led[c] = 1'b1;
               1:       m_led[c] = ~ph_fast;
               2, 3:    m_led[c] = ~ph_slow;
               default: m_led[c] = 1'b0;
            endcase
            m_txdis[c]   = s_los || (m_los_run[c] < HOLD);
            m_los_run[c] = s_los ? 0 : m_los_run[c] + 1;
            m_press_run[c] = s_btn ? m_press_run[c] + 1 : 0;
            m_pulse[c]   = (m_press_run[c] == DEB);
            if (!s_pll)               cap = 0;
            else if (!s_sig || s_los) cap = 1;
            else if (!s_cdr)          cap = 2;
            else                      cap = 4;
            nst = m_st[c];
            if (m_st[c] > cap) nst = cap;
            else if (m_st[c] < cap) begin
               if (m_st[c] == 2) begin
                  nst = 3;
                  m_qual_age[c] = 0;
               end else if (m_st[c] == 3) begin
                  m_qual_age[c]++;
                  if (m_qual_age[c] == QUAL) nst = 4;
               end else nst = m_st[c] + 1;
            end
            if (m_st[c] == 4 && nst != 4 && m_drops[c] < 255) m_drops[c]++;
            if (m_pulse[c]) m_drops[c] = 0;
            m_st[c] = nst;
            m_drop_vec[8*c +: 8] = 8'(m_drops[c]);
            m_d2[c] = m_d1[c];
            m_d1[c] = {btn_clear[c], sfp_los[c], sig_det[c], cdr_lock[c], pll_lock[c]};
         end
         m_cyc++;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("tx_disable", sfp_tx_disable, m_txdis);
         chk("ber_clear", ber_clear, m_pulse);
         chk("blkerr_clear", blkerr_clear, m_pulse);
         chk("link_up", link_up, m_up);
         chk("leds_n", leds_n, m_led);
         chk("drop_cnt", drop_cnt, m_drop_vec);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   int up_at, tx_at, pulses, k;
   int tmr[NUM_CH][5];
   bit v;

   initial begin
      // Power-up with all locks good and LOS low.
      cycles(3);
      chk("rst_txdis", sfp_tx_disable, 2'b11);
      chk("rst_leds", leds_n, 2'b11);
      chk("rst_link", link_up, 2'b00);
      rst = 1'b0;
      up_at = 0; tx_at = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (link_up[0] && up_at == 0) up_at = i;
         if (!sfp_tx_disable[0] && tx_at == 0) tx_at = i;
         if (up_at != 0 && tx_at != 0) break;
      end
      chk("up_latency", up_at, QUAL + 6);
      chk("tx_holdoff", tx_at, HOLD + 3);
      chk("led_solid", leds_n[0], 0);

      // CDR drop on channel 1 while up.
      cdr_lock[1] = 1'b0;
      cycles(10);
      chk("drop_ch1", drop_cnt[15:8], 1);
      cdr_lock[1] = 1'b1;
      for (k = 0; k < 60; k++) begin
         @(negedge clk);
         if (link_up[1]) break;
      end
      chk("relink_ch1", link_up[1], 1);

      // 300 drops on channel 0 saturate the counter.
      for (int d = 0; d < 300; d++) begin
         cdr_lock[0] = 1'b0;
         cycles(4);
         cdr_lock[0] = 1'b1;
         for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (link_up[0]) break;
         end
      end
      chk("drop_sat", drop_cnt[7:0], 255);

      // Long press clears it with exactly one pulse.
      btn_clear[0] = 1'b1;
      pulses = 0;
      for (int i = 0; i < 3 * DEB; i++) begin
         @(negedge clk);
         if (ber_clear[0]) pulses++;
      end
      chk("press_pulses", pulses, 1);
      chk("drop_cleared", drop_cnt[7:0], 0);
      btn_clear[0] = 1'b0;

      // Bouncing button, then a long hold: one pulse overall.
      pulses = 0;
      for (int t = 0; t < 12; t++) begin
         btn_clear[1] = ~btn_clear[1];
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ber_clear[1]) pulses++;
         end
      end
      btn_clear[1] = 1'b1;
      for (int i = 0; i < 3 * DEB; i++) begin
         @(negedge clk);
         if (ber_clear[1]) pulses++;
      end
      chk("bounce_pulses", pulses, 1);
      btn_clear[1] = 1'b0;
      cycles(3);

      // One-cycle LOS glitch in the middle of the TX hold-off.
      sfp_los[1] = 1'b1;
      cycles(20);
      sfp_los[1] = 1'b0;
      cycles(20);
      sfp_los[1] = 1'b1;
      cycles(1);
      sfp_los[1] = 1'b0;
      for (k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (!sfp_tx_disable[1]) break;
      end
      chk("hold_restart", k, HOLD + 3);
      cycles(30);

      // Reset while channel 0 qualifies with a clear pulse about to fire.
      btn_clear[0] = 1'b1;
      pll_lock[0]  = 1'b0;
      cycles(10);
      pll_lock[0]  = 1'b1;
      cycles(11);
      rst = 1'b1;
      cycles(1);
      chk("mid_rst_txdis", sfp_tx_disable, 2'b11);
      chk("mid_rst_ber", ber_clear, 2'b00);
      chk("mid_rst_blkerr", blkerr_clear, 2'b00);
      chk("mid_rst_link", link_up, 2'b00);
      chk("mid_rst_drop", drop_cnt, 16'h0000);
      chk("mid_rst_leds", leds_n, 2'b11);
      btn_clear[0] = 1'b0;
      rst = 1'b0;
      cycles(40);

      // Random pin activity, biased toward a healthy link.
      for (int c = 0; c < NUM_CH; c++)
         for (int s = 0; s < 5; s++) tmr[c][s] = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < 5; s++) begin
               if (tmr[c][s] == 0) begin
                  v = ($urandom_range(0, 99) < 85);
                  case (s)
                     0: pll_lock[c]  = v;
                     1: cdr_lock[c]  = v;
                     2: sig_det[c]   = v;
                     3: sfp_los[c]   = ~v;
                     default: btn_clear[c] = $urandom_range(0, 1) == 1;
                  endcase
                  tmr[c][s] = (s == 4) ? $urandom_range(1, 50) : $urandom_range(1, 60);
               end else tmr[c][s]--;
            end
         end
      end
      cycles(5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
